decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage and return path of the fetch interface. Consumes instr/pc from fetch.
//  Holds the IF/ID register, decodes control and resolves branches in ID. Drives
//  branch/zero/branchTargetAddr back to fetch. Issues stall on load-use hazards and
//  fills the ID/EX register consumed by execute.
// PARAMETERS
//  WIDTH      32  datapath/address width (= `width)
//  REG_AW     5   register index width
// PORTS
//  clk               in   1        rising-edge clock
//  rst               in   1        synchronous reset, active-high
//  instr             in   WIDTH    instruction from fetch
//  pc                in   WIDTH    byte address of instr
//  rs_addr           out  REG_AW   regfile read port A index (comb from IF/ID)
//  rt_addr           out  REG_AW   regfile read port B index (comb from IF/ID)
//  rs_data           in   WIDTH    regfile read data A (comb)
//  rt_data           in   WIDTH    regfile read data B (comb)
//  branch            out  1        IF/ID holds valid beq/bne and no stall
//  zero              out  1        branch condition true (beq: rs==rt; bne: rs!=rt)
//  branchTargetAddr  out  WIDTH    if_id_pc + 4 + (sext(imm16) << 2)
//  stall             out  1        fetch must hold pc/instr this cycle
//  idex_valid        out  1        ID/EX slot holds a real instruction
//  idex_ctrl         out  ctrl_t   regwrite,memread,memwrite,alusrc,memtoreg,aluop
//  idex_rs_data      out  WIDTH    latched rs_data
//  idex_rt_data      out  WIDTH    latched rt_data
//  idex_imm          out  WIDTH    sign-extended imm16
//  idex_dst          out  REG_AW   write-back index (rd for R-type, rt for lw/addi)
//  idex_funct        out  6        funct field
//  illegal           out  1        pulse: valid IF/ID opcode unsupported
// BEHAVIOUR
//  - Reset: IF/ID and ID/EX cleared. valid=0, instr=0, all ctrl=0, idex_* = 0.
//    branch=0, zero=0, stall=0, illegal=0. Reset has priority over stall and flush.
//  - Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08.
//    Any other opcode decodes as nop (all ctrl 0). illegal is high for that cycle.
//  - IF/ID capture: each edge loads {instr, pc, valid=1} unless stall or flush.
//  - Stall: IF/ID holds its value. ID/EX loads a bubble (valid=0, ctrl=0).
//  - Flush: next edge loads IF/ID with a bubble (valid=0, instr=0).
//    Flush = branch & zero & !stall. There is no delay slot.
//  - ID/EX normal: latches decoded fields with valid=if_id_valid. Latency 1 cycle.
//  - Load-use stall (comb): idex_valid & idex_ctrl.memread & idex_dst!=0 &
//    idex_dst in {rs, rt of IF/ID}. rt compares only if IF/ID reads rt (R-type/sw/beq/bne).
//  - Branch-operand stall: IF/ID is beq/bne & idex_valid & idex_ctrl.regwrite &
//    idex_dst!=0 & idex_dst in {rs, rt}. ID branch resolution has no forwarding.
//  - Stall lasts until the hazard clears: one cycle for ALU producers, one cycle for
//    lw then re-check. branch is forced 0 while stall=1.
//  - Register 0 never causes a hazard.
//  - Target arithmetic is mod 2^WIDTH, wraps silently. imm is sign-extended from bit 15.
//  - Invalid IF/ID (bubble) drives branch=0, stall=0, illegal=0.
//  - Simultaneous stall and taken branch cannot occur, because branch is gated by !stall.
// STRUCTURE
//  - mips_pkg: opcode/funct localparams, ctrl_t packed struct, aluop enum, NOP constant.
//  - Sub-module main_control: purely combinational opcode -> ctrl_t, plus illegal.
//  - Hazard detect, branch compare and both pipeline registers stay in decode_stage.
// TESTING
//  1 Reset: rst=1 for 3 edges -> all outputs 0. First instr after release appears on
//    idex_* 2 edges later with idex_valid=1.
//  2 addi $1,$0,5 @pc=0x10 -> idex_imm=5, idex_dst=1, regwrite=1, alusrc=1, no stall.
//  3 beq rs=rt=7, imm=0x0003 @pc=0x20 -> branch=1, zero=1, target=0x30. Next IF/ID
//    is a bubble. With rs!=rt: zero=0 and no flush.
//  4 lw $2 then add $3,$2,$4 -> stall=1 for exactly 1 cycle. ID/EX bubble, add issues
//    next cycle with unchanged fields.
//  5 add $5 then beq $5,$0 -> 1-cycle stall with branch=0 during the stall.
//    lw $0 then add using $0 -> no stall.
//  6 opcode 0x3F -> illegal pulse, ctrl=0. imm=0x8000 @pc=0xFFFFFFF0 -> target wraps
//    to 0xFFFDFFF4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode types: opcode/funct encodings, control bundle and ALU op select.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_RTYPE = 2'd2
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   alusrc;
        logic   memtoreg;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                   alusrc: 1'b0, memtoreg: 1'b0, aluop: ALU_ADD};

endpackage

// File: rtl/decode_stage_main_control.sv
// Main control: purely combinational opcode -> control bundle, flags unknown opcodes.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Opcode decode; unsupported opcodes fall through to an all-zero nop.
    always_comb begin
        ctrl    = NOP_CTRL;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_RTYPE;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.aluop = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, control decode, in-ID branch resolution, load-use and
// branch-operand hazard stall, and the ID/EX register feeding execute.
module decode_stage
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  instr,
    input  logic [WIDTH-1:0]  pc,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    output logic              branch,
    output logic              zero,
    output logic [WIDTH-1:0]  branchTargetAddr,
    output logic              stall,
    output logic              idex_valid,
    output ctrl_t             idex_ctrl,
    output logic [WIDTH-1:0]  idex_rs_data,
    output logic [WIDTH-1:0]  idex_rt_data,
    output logic [WIDTH-1:0]  idex_imm,
    output logic [REG_AW-1:0] idex_dst,
    output logic [5:0]        idex_funct,
    output logic              illegal
);

    logic [WIDTH-1:0]  if_id_instr;
    logic [WIDTH-1:0]  if_id_pc;
    logic              if_id_valid;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd, dst;
    logic [15:0]       imm16;
    logic [WIDTH-1:0]  imm_ext;
    ctrl_t             ctrl_dec, ctrl_id;
    logic              illegal_dec;
    logic              is_branch, reads_rt, load_use, branch_haz, cond, flush;

    assign opcode  = if_id_instr[31:26];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign imm16   = if_id_instr[15:0];
    assign imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};
    assign rs_addr = rs;
    assign rt_addr = rt;

    main_control u_main_control (
        .opcode  (opcode),
        .ctrl    (ctrl_dec),
        .illegal (illegal_dec)
    );

    // Hazard detection and branch resolution; a bubble in IF/ID drives everything low.
    always_comb begin
        ctrl_id    = if_id_valid ? ctrl_dec : NOP_CTRL;
        dst        = (opcode == OP_RTYPE) ? rd : rt;
        is_branch  = if_id_valid && (opcode == OP_BEQ || opcode == OP_BNE);
        reads_rt   = opcode == OP_RTYPE || opcode == OP_SW ||
                     opcode == OP_BEQ   || opcode == OP_BNE;
        load_use   = idex_valid && idex_ctrl.memread && idex_dst != '0 &&
                     (idex_dst == rs || (reads_rt && idex_dst == rt));
        // No forwarding into ID compare: any in-flight writer of a branch operand stalls.
        branch_haz = is_branch && idex_valid && idex_ctrl.regwrite && idex_dst != '0 &&
                     (idex_dst == rs || idex_dst == rt);
        stall      = if_id_valid && (load_use || branch_haz);
        branch     = is_branch && !stall;
        cond       = (opcode == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
        zero       = branch && cond;
        flush      = branch && zero;
        illegal    = if_id_valid && illegal_dec;
        branchTargetAddr = if_id_pc + WIDTH'(4) + (imm_ext << 2);
    end

    // IF/ID: hold on stall, squash the fall-through instruction on a taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_instr <= if_id_instr;
        end else if (flush) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            if_id_instr <= instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
        end
    end

    // ID/EX: decoded fields, or an all-zero bubble while the stall holds IF/ID.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            idex_valid   <= 1'b0;
            idex_ctrl    <= NOP_CTRL;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_dst     <= '0;
            idex_funct   <= '0;
        end else begin
            idex_valid   <= if_id_valid;
            idex_ctrl    <= ctrl_id;
            idex_rs_data <= rs_data;
            idex_rt_data <= rt_data;
            idex_imm     <= imm_ext;
            idex_dst     <= dst;
            idex_funct   <= if_id_instr[5:0];
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, branch flush, hazards, illegal, wrap.
module tb_decode_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        branch, zero, stall, idex_valid, illegal;
    logic [31:0] branchTargetAddr, idex_rs_data, idex_rt_data, idex_imm;
    ctrl_t       idex_ctrl;
    logic [4:0]  idex_dst;
    logic [5:0]  idex_funct;

    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .branch(branch), .zero(zero), .branchTargetAddr(branchTargetAddr), .stall(stall),
        .idex_valid(idex_valid), .idex_ctrl(idex_ctrl), .idex_rs_data(idex_rs_data),
        .idex_rt_data(idex_rt_data), .idex_imm(idex_imm), .idex_dst(idex_dst),
        .idex_funct(idex_funct), .illegal(illegal)
    );

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] f);
        return {OP_RTYPE, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = itype(OP_ADDI, 5'd0, 5'd1, 16'd5); pc = 32'h10;
        repeat (3) step();
        n_tests++; if (idex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idex_valid got %b exp 0", idex_valid); end
        n_tests++; if (idex_ctrl !== NOP_CTRL) begin n_fail++; $display("FAIL reset_idex_ctrl got %h exp 0", idex_ctrl); end
        n_tests++; if ({idex_imm, idex_dst, idex_funct, idex_rs_data} !== '0) begin n_fail++; $display("FAIL reset_idex_fields got %h/%h/%h exp 0", idex_imm, idex_dst, idex_funct); end
        n_tests++; if ({branch, zero, stall, illegal} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {branch, zero, stall, illegal}); end
        n_tests++; if ({rs_addr, rt_addr} !== 10'd0) begin n_fail++; $display("FAIL reset_ifid got %h exp 0", {rs_addr, rt_addr}); end
    endtask

    task automatic test_addi();
        rst = 1'b0;
        step();
        n_tests++; if (idex_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL addi_edge1 got valid=%b stall=%b exp 0 0", idex_valid, stall); end
        n_tests++; if (rt_addr !== 5'd1) begin n_fail++; $display("FAIL addi_ifid_rt got %0d exp 1", rt_addr); end
        instr = 32'h0; pc = 32'h14;
        step();
        n_tests++; if (idex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", idex_valid); end
        n_tests++; if (idex_imm !== 32'd5 || idex_dst !== 5'd1) begin n_fail++; $display("FAIL addi_fields got imm=%h dst=%0d exp 5 1", idex_imm, idex_dst); end
        n_tests++; if (idex_ctrl.regwrite !== 1'b1 || idex_ctrl.alusrc !== 1'b1 || idex_ctrl.memread !== 1'b0) begin n_fail++; $display("FAIL addi_ctrl got %h exp rw=1 src=1 mr=0", idex_ctrl); end
    endtask

    task automatic test_branch();
        instr = itype(OP_BEQ, 5'd6, 5'd7, 16'h0003); pc = 32'h20;
        step();
        n_tests++; if (branch !== 1'b1 || zero !== 1'b1) begin n_fail++; $display("FAIL beq_taken got branch=%b zero=%b exp 1 1", branch, zero); end
        n_tests++; if (branchTargetAddr !== 32'h30) begin n_fail++; $display("FAIL beq_target got %h exp 00000030", branchTargetAddr); end
        instr = itype(OP_ADDI, 5'd3, 5'd9, 16'd1); pc = 32'h24;
        step();
        n_tests++; if (rs_addr !== 5'd0 || branch !== 1'b0) begin n_fail++; $display("FAIL beq_flush got rs_addr=%0d branch=%b exp 0 0", rs_addr, branch); end
        n_tests++; if (idex_valid !== 1'b1 || idex_ctrl.aluop !== ALU_SUB) begin n_fail++; $display("FAIL beq_idex got valid=%b aluop=%0d exp 1 1", idex_valid, idex_ctrl.aluop); end
        instr = 32'h0; pc = 32'h28;
        step();
        n_tests++; if (idex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got %b exp 0", idex_valid); end
        instr = itype(OP_BEQ, 5'd6, 5'd8, 16'h0003); pc = 32'h40;
        step();
        n_tests++; if (branch !== 1'b1 || zero !== 1'b0) begin n_fail++; $display("FAIL beq_nt got branch=%b zero=%b exp 1 0", branch, zero); end
        n_tests++; if (branchTargetAddr !== 32'h50) begin n_fail++; $display("FAIL beq_nt_target got %h exp 00000050", branchTargetAddr); end
        instr = itype(OP_ADDI, 5'd3, 5'd9, 16'd1); pc = 32'h44;
        step();
        n_tests++; if (rs_addr !== 5'd3) begin n_fail++; $display("FAIL beq_noflush got rs_addr=%0d exp 3", rs_addr); end
        instr = 32'h0;
        step(); step();
    endtask

    task automatic test_load_use();
        instr = itype(OP_LW, 5'd1, 5'd2, 16'd0); pc = 32'h60;
        step();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_nostall got %b exp 0", stall); end
        instr = rtype(5'd2, 5'd4, 5'd3, FUNCT_ADD); pc = 32'h64;
        step();
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", stall); end
        step();
        n_tests++; if (stall !== 1'b0 || idex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got stall=%b valid=%b exp 0 0", stall, idex_valid); end
        n_tests++; if (rs_addr !== 5'd2 || rt_addr !== 5'd4) begin n_fail++; $display("FAIL lu_hold got rs=%0d rt=%0d exp 2 4", rs_addr, rt_addr); end
        instr = 32'h0; pc = 32'h68;
        step();
        n_tests++; if (idex_valid !== 1'b1 || idex_dst !== 5'd3 || idex_funct !== FUNCT_ADD) begin n_fail++; $display("FAIL lu_issue got valid=%b dst=%0d funct=%h exp 1 3 20", idex_valid, idex_dst, idex_funct); end
        n_tests++; if (idex_rs_data !== rf[2] || idex_rt_data !== rf[4]) begin n_fail++; $display("FAIL lu_data got %h %h exp %h %h", idex_rs_data, idex_rt_data, rf[2], rf[4]); end
        step();
    endtask

    task automatic test_branch_hazard();
        instr = rtype(5'd1, 5'd2, 5'd5, FUNCT_ADD); pc = 32'h80;
        step();
        instr = itype(OP_BEQ, 5'd5, 5'd0, 16'h0002); pc = 32'h84;
        step();
        n_tests++; if (stall !== 1'b1 || branch !== 1'b0) begin n_fail++; $display("FAIL bh_stall got stall=%b branch=%b exp 1 0", stall, branch); end
        step();
        n_tests++; if (stall !== 1'b0 || branch !== 1'b1 || zero !== 1'b0) begin n_fail++; $display("FAIL bh_resolve got stall=%b branch=%b zero=%b exp 0 1 0", stall, branch, zero); end
        instr = itype(OP_LW, 5'd1, 5'd0, 16'd0); pc = 32'h88;
        step();
        instr = rtype(5'd0, 5'd0, 5'd6, FUNCT_ADD); pc = 32'h8C;
        step();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_nostall got %b exp 0", stall); end
        instr = 32'h0;
        step();
    endtask

    task automatic test_illegal_wrap();
        instr = {6'h3F, 26'h0123456}; pc = 32'hA0;
        step();
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got %b exp 1", illegal); end
        instr = 32'h0; pc = 32'hA4;
        step();
        n_tests++; if (illegal !== 1'b0 || idex_valid !== 1'b1 || idex_ctrl !== NOP_CTRL) begin n_fail++; $display("FAIL illegal_nop got ill=%b valid=%b ctrl=%h exp 0 1 0", illegal, idex_valid, idex_ctrl); end
        instr = itype(OP_BEQ, 5'd6, 5'd7, 16'h8000); pc = 32'hFFFF_FFF0;
        step();
        n_tests++; if (branchTargetAddr !== 32'hFFFD_FFF4) begin n_fail++; $display("FAIL target_wrap got %h exp fffdfff4", branchTargetAddr); end
        instr = 32'h0; pc = 32'h0;
        step(); step();
        instr = itype(OP_BNE, 5'd6, 5'd8, 16'h0001); pc = 32'h100;
        step();
        n_tests++; if (branch !== 1'b1 || zero !== 1'b1 || branchTargetAddr !== 32'h108) begin n_fail++; $display("FAIL bne_taken got b=%b z=%b t=%h exp 1 1 00000108", branch, zero, branchTargetAddr); end
        instr = 32'h0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'h0; rf[5] = 32'd3; rf[6] = 32'd7; rf[7] = 32'd7; rf[8] = 32'd8;
        rst = 1'b1; instr = 32'h0; pc = 32'h0;
        test_reset();
        test_addi();
        test_branch();
        test_load_use();
        test_branch_hazard();
        test_illegal_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
